// File: rtl/func_sweep_ctrl.sv
// func_sweep_ctrl: exhaustive truth-table sweep and compare of an N_IN-input function; define SWEEP_FIRST_FAIL_EN to add first-mismatch capture
module func_sweep_ctrl #(
    parameter int N_IN   = 5,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic [N_IN:0]        mismatch_cnt,
`ifdef SWEEP_FIRST_FAIL_EN
    output logic                 first_fail_vld,
    output logic [N_IN-1:0]      first_fail_idx,
`endif
    output logic                 pass
);
    localparam int T = 2**N_IN;
    localparam int CW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] SET = CW'(SETTLE);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [T-1:0] exp_q;
    logic miss;
    logic [N_IN:0] mc_n;
    assign miss = dut_out != exp_q[dut_in];
    assign mc_n = mismatch_cnt + {{N_IN{1'b0}}, miss};
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            exp_q        <= '0;
            dut_in       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
`ifdef SWEEP_FIRST_FAIL_EN
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state        <= RUN;
                    busy         <= 1'b1;
                    exp_q        <= expected;
                    dut_in       <= '0;
                    cnt          <= '0;
                    table_out    <= '0;
                    mismatch_cnt <= '0;
                    pass         <= 1'b0;
`ifdef SWEEP_FIRST_FAIL_EN
                    first_fail_vld <= 1'b0;
                    first_fail_idx <= '0;
`endif
                end
                RUN: if (cnt != SET) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    cnt               <= '0;
                    table_out[dut_in] <= dut_out;
                    mismatch_cnt      <= mc_n;
`ifdef SWEEP_FIRST_FAIL_EN
                    if (miss && !first_fail_vld) begin
                        first_fail_vld <= 1'b1;
                        first_fail_idx <= dut_in;
                    end
`endif
                    // pass uses mc_n so the final sample is included
                    if (&dut_in) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= mc_n == '0;
                    end else begin
                        dut_in <= dut_in + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_func_sweep_ctrl.sv
// tb_func_sweep_ctrl: directed checks of func_sweep_ctrl with a parity function (SETTLE=1) and a stuck-at-0 function (SETTLE=0)
module tb_func_sweep_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic [31:0] exp_a = '0;
    logic [31:0] exp_b = '0;
    logic [4:0] in_a, in_b;
    logic busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [31:0] tab_a, tab_b;
    logic [5:0] mc_a, mc_b;
`ifdef SWEEP_FIRST_FAIL_EN
    logic ffv_a, ffv_b;
    logic [4:0] ffi_a, ffi_b;
`endif
    int n_chk = 0;
    int n_fail = 0;
    int cyc, bcnt, seq_err;

    always #5 clk = ~clk;

    func_sweep_ctrl #(.N_IN(5), .SETTLE(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .expected(exp_a),
        .dut_in(in_a), .dut_out(^in_a), .busy(busy_a), .done(done_a),
        .table_out(tab_a), .mismatch_cnt(mc_a),
`ifdef SWEEP_FIRST_FAIL_EN
        .first_fail_vld(ffv_a), .first_fail_idx(ffi_a),
`endif
        .pass(pass_a)
    );

    func_sweep_ctrl #(.N_IN(5), .SETTLE(0)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .expected(exp_b),
        .dut_in(in_b), .dut_out(1'b0), .busy(busy_b), .done(done_b),
        .table_out(tab_b), .mismatch_cnt(mc_b),
`ifdef SWEEP_FIRST_FAIL_EN
        .first_fail_vld(ffv_b), .first_fail_idx(ffi_b),
`endif
        .pass(pass_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // mode: 0 plain, 1 extra start pulse mid-sweep, 2 expected changed mid-sweep, 3 start left high
    task automatic sweep(input bit sel, input logic [31:0] e, input int mode);
        if (sel) begin
            exp_b = e;
            start_b = 1'b1;
        end else begin
            exp_a = e;
            start_a = 1'b1;
        end
        tick();
        if (mode != 3) begin
            start_a = 1'b0;
            start_b = 1'b0;
        end
        cyc = 1;
        bcnt = 0;
        seq_err = 0;
        while (!(sel ? done_b : done_a) && cyc < 200) begin
            if (sel ? busy_b : busy_a) begin
                bcnt++;
                if ((sel ? in_b : in_a) != 5'(sel ? cyc - 1 : (cyc - 1) / 2)) seq_err++;
            end
            if (mode == 1) start_a = cyc == 10;
            if (mode == 2 && cyc == 20) exp_a = '0;
            tick();
            cyc++;
        end
        chk("done_cyc", cyc, sel ? 33 : 65);
        chk("busy_cnt", bcnt, sel ? 32 : 64);
        chk("dut_in_seq", seq_err, 0);
        chk("busy_at_done", 32'(sel ? busy_b : busy_a), 0);
        tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_dut_in", 32'(in_a), 0);
        chk("rst_table", tab_a, 0);
        chk("rst_mc", 32'(mc_a), 0);
        chk("rst_pass", 32'(pass_a), 0);
        rst = 1'b0;
        tick();

        sweep(0, 32'h96696996, 0);
        chk("par_table", tab_a, 32'h96696996);
        chk("par_mc", 32'(mc_a), 0);
        chk("par_pass", 32'(pass_a), 1);
        chk("done_one_cycle", 32'(done_a), 0);
        chk("dut_in_hold", 32'(in_a), 31);
`ifdef SWEEP_FIRST_FAIL_EN
        chk("par_ff_vld", 32'(ffv_a), 0);
`endif

        sweep(0, 32'h96696997, 1);
        chk("mis1_table", tab_a, 32'h96696996);
        chk("mis1_mc", 32'(mc_a), 1);
        chk("mis1_pass", 32'(pass_a), 0);
`ifdef SWEEP_FIRST_FAIL_EN
        chk("mis1_ff_vld", 32'(ffv_a), 1);
        chk("mis1_ff_idx", 32'(ffi_a), 0);
`endif

        sweep(1, 32'hFFFFFFFF, 0);
        chk("all_table", tab_b, 0);
        chk("all_mc", 32'(mc_b), 32);
        chk("all_pass", 32'(pass_b), 0);
`ifdef SWEEP_FIRST_FAIL_EN
        chk("all_ff_vld", 32'(ffv_b), 1);
        chk("all_ff_idx", 32'(ffi_b), 0);
`endif

        sweep(0, 32'h96696996, 2);
        chk("latch_table", tab_a, 32'h96696996);
        chk("latch_mc", 32'(mc_a), 0);
        chk("latch_pass", 32'(pass_a), 1);

        sweep(0, 32'h96696996, 3);
        chk("hold_idle_busy", 32'(busy_a), 0);
        chk("hold_idle_done", 32'(done_a), 0);
        tick();
        chk("hold_restart_busy", 32'(busy_a), 1);
        chk("hold_restart_in", 32'(in_a), 0);
        start_a = 1'b0;
        cyc = 0;
        while (!done_a && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("hold_done", 32'(done_a), 1);
        chk("hold_pass", 32'(pass_a), 1);
        tick();

        start_a = 1'b1;
        exp_a = '0;
        tick();
        start_a = 1'b0;
        repeat (19) tick();
        chk("pre_rst_busy", 32'(busy_a), 1);
        chk("pre_rst_mc", 32'(mc_a), 5);
        rst = 1'b1;
        tick();
        chk("abort_busy", 32'(busy_a), 0);
        chk("abort_done", 32'(done_a), 0);
        chk("abort_dut_in", 32'(in_a), 0);
        chk("abort_table", tab_a, 0);
        chk("abort_mc", 32'(mc_a), 0);
        chk("abort_pass", 32'(pass_a), 0);
        rst = 1'b0;
        tick();
        chk("abort_no_done", 32'(done_a), 0);

        sweep(0, 32'h96696996, 0);
        chk("after_rst_pass", 32'(pass_a), 1);
        chk("after_rst_table", tab_a, 32'h96696996);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/func_sweep_ctrl.md
Name: func_sweep_ctrl

Overview:
- Sequential controller that exhaustively exercises a combinational N_IN-input, 1-output logic function built from coder cells, e.g. the 5-input lab functions.
- Drives every input vector 0..2^N_IN-1 in order and waits a programmable settle time before sampling each result.
- Assembles the measured truth table, compares it bit-by-bit against an expected table and reports pass/fail with a mismatch count.
- Sits between the on-board control (start button or sequencer) and the function under evaluation.

Parameters:
- N_IN, 5, width of the function input vector; table size is 2^N_IN.
- SETTLE, 1, extra wait cycles after applying a vector before sampling; 0 is legal.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  begin sweep; sampled only in IDLE
- expected  input  2^N_IN  expected truth table; bit i is the output for vector i; latched on accepted start
- dut_in  output  N_IN  registered input vector driven to the function
- dut_out  input  1  function output (combinational from dut_in)
- busy  output  1  high while sweeping
- done  output  1  one-cycle pulse when results become valid
- table_out  output  2^N_IN  measured truth table
- mismatch_cnt  output  N_IN+1  number of differing table bits (0..2^N_IN)
- pass  output  1  high when the last sweep had mismatch_cnt==0

Behaviour:
- Reset values:
  - State: IDLE.
  - All outputs 0, including dut_in, busy, done, table_out, mismatch_cnt and pass.
  - Internal idx, settle counter and latched expected are cleared.
- State IDLE:
  - busy=0.
  - On start=1, go to RUN.
  - Same edge: latch expected, set idx=0, dut_in=0, cnt=0, clear table_out, mismatch_cnt and pass.
- State RUN:
  - busy=1; dut_in always equals idx.
  - Each cycle with cnt<SETTLE: cnt increments.
  - When cnt==SETTLE, on that edge:
    - table_out[idx] <= dut_out.
    - If dut_out != expected_latched[idx], mismatch_cnt increments.
    - cnt <= 0.
    - If idx == 2^N_IN-1, go to DONE; else idx and dut_in increment.
  - Each vector occupies exactly SETTLE+1 cycles.
  - busy is high for 2^N_IN*(SETTLE+1) cycles.
- State DONE:
  - One cycle only: done=1, busy=0, pass=(mismatch_cnt==0); then IDLE.
  - done uses the final count, including the last sample.
  - table_out, mismatch_cnt and pass hold until the next accepted start or rst.
- start handling:
  - Ignored in RUN and DONE.
  - Level-sensitive in IDLE: start held high causes back-to-back sweeps separated by the DONE cycle.
- dut_in holds the last vector (2^N_IN-1) after a sweep until the next start or rst.
- Counter widths:
  - mismatch_cnt has N_IN+1 bits and cannot overflow: all-mismatch gives exactly 2^N_IN.
  - The settle counter is wide enough for SETTLE, minimum 1 bit.
- rst mid-sweep:
  - Aborts immediately; next cycle all outputs are at reset values.
  - No done pulse.
  - Partial table is discarded.
- Changes to expected after start has no effect on the running sweep.

Optional Feature:
- Macro: SWEEP_FIRST_FAIL_EN.
- When defined, two output ports are added:
  - first_fail_vld (1 bit).
  - first_fail_idx (N_IN bits): index of the first vector whose sample mismatched.
- Both are cleared on rst and on accepted start.
- On the first mismatch sample only: first_fail_vld<=1, first_fail_idx<=idx.
- Both hold until the next start or rst.
- The sweep does not stop on a mismatch.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Parity model (dut_out = XOR of dut_in), expected=32'h96696996, SETTLE=1, start pulse:
  - busy high exactly 64 cycles, done pulse on cycle 65 after the start edge.
  - table_out=32'h96696996, mismatch_cnt=0, pass=1.
- Same model, expected=32'h96696997 -> mismatch_cnt=1, pass=0; with SWEEP_FIRST_FAIL_EN, first_fail_vld=1 and first_fail_idx=0.
- dut_out tied 0, expected=32'hFFFFFFFF, SETTLE=0:
  - busy exactly 32 cycles, mismatch_cnt=32 (6'b100000), table_out=0, pass=0.
  - With SWEEP_FIRST_FAIL_EN: first_fail_idx=0.
- SETTLE=1, monitor dut_in:
  - Sequence is 0,0,1,1,...,31,31 during busy, then holds 31.
  - start pulses during busy are ignored; start held high gives a new sweep beginning the cycle after done.
- rst asserted on cycle 20 of a sweep:
  - Next cycle busy=0, done=0, dut_in=0, table_out=0, mismatch_cnt=0, pass=0.
  - A following start with the parity model completes with pass=1.
- Change expected to 0 mid-sweep with the parity model -> result unchanged (pass=1), proving the latch-at-start behaviour.
